// File: rtl/uart_txrx_pkg.sv
// Shared types and helpers for the UART bit engine.
// Defining UART_TXRX_PARITY_EN adds an even-parity bit to both directions.
package uart_txrx_pkg;
    localparam int DATA_BITS   = 8;
    localparam int DEF_MIN_DIV = 4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_TXRX_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_TXRX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAITHI
    } rx_state_e;

    function automatic logic [31:0] div_clamp(input logic [31:0] div, input logic [31:0] min_div);
        return (div < min_div) ? min_div : div;
    endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// Rx path: synchroniser, start detect, mid-bit sampling FSM and frame/parity error reporting.
// Parity checking is present only when UART_TXRX_PARITY_EN is defined.
module uart_rx_sampler
    import uart_txrx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_div_eff,
    input  logic        i_rx,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_frame_err
);
    rx_state_e              r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_d;
    logic [31:0]            r_cnt, r_div;
    logic [7:0]             r_shift;
    logic [2:0]             r_bit;
    logic                   w_rx, w_fall, w_tick, w_good, w_bad;
`ifdef UART_TXRX_PARITY_EN
    logic                   r_par_err;
`endif

    assign w_rx   = r_sync[SYNC_STAGES-1];
    assign w_fall = r_rx_d & ~w_rx;
    assign w_tick = (r_cnt == 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_rx_d <= w_rx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RX_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:   if (w_fall) w_next = RX_START;
            RX_START:  if (w_tick) w_next = w_rx ? RX_IDLE : RX_DATA;
`ifdef UART_TXRX_PARITY_EN
            RX_DATA:   if (w_tick && r_bit == 3'(DATA_BITS-1)) w_next = RX_PARITY;
            RX_PARITY: if (w_tick) w_next = RX_STOP;
`else
            RX_DATA:   if (w_tick && r_bit == 3'(DATA_BITS-1)) w_next = RX_STOP;
`endif
            RX_STOP:   if (w_tick) w_next = w_rx ? RX_IDLE : RX_WAITHI;
            RX_WAITHI: if (w_rx) w_next = RX_IDLE;
            default:   w_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_good = 1'b0;
        w_bad  = 1'b0;
        if (r_state == RX_STOP && w_tick) begin
`ifdef UART_TXRX_PARITY_EN
            w_good = w_rx & ~r_par_err;
            w_bad  = ~w_rx | r_par_err;
`else
            w_good = w_rx;
            w_bad  = ~w_rx;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_div       <= '0;
            r_shift     <= '0;
            r_bit       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_TXRX_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            o_valid     <= w_good;
            o_frame_err <= w_bad;
            if (w_good) o_data <= r_shift;
            if (r_state == RX_IDLE) begin
                // First sample lands mid start bit; later ones a full bit apart.
                if (w_fall) begin
                    r_cnt <= i_div_eff >> 1;
                    r_div <= i_div_eff;
                    r_bit <= '0;
`ifdef UART_TXRX_PARITY_EN
                    r_par_err <= 1'b0;
`endif
                end
            end else if (w_tick) begin
                r_cnt <= r_div;
                if (r_state == RX_DATA) begin
                    r_shift <= {w_rx, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
                end
`ifdef UART_TXRX_PARITY_EN
                if (r_state == RX_PARITY) r_par_err <= (^r_shift) ^ w_rx;
`endif
            end else begin
                r_cnt <= r_cnt - 32'd1;
            end
        end
    end
endmodule

// File: rtl/uart_txrx_core.sv
// UART bit engine under the register block: Tx FSM here, Rx in uart_rx_sampler.
// Defining UART_TXRX_PARITY_EN switches framing from 8N1 to 8E1.
module uart_txrx_core
    import uart_txrx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_DIV     = DEF_MIN_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] baud_div,
    input  logic [7:0]  tx_data,
    input  logic        tx_start,
    output logic        tx_busy,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_frame_err,
    output logic        tx,
    input  logic        rx
);
    tx_state_e   r_tx_state, w_tx_next;
    logic [31:0] r_tx_cnt, r_tx_div, w_div_eff;
    logic [7:0]  r_tx_shift;
    logic [2:0]  r_tx_bit;
    logic        r_tx_par;
    logic        w_tx_accept, w_tx_tick;

    assign w_div_eff   = div_clamp(baud_div, 32'(MIN_DIV));
    assign w_tx_accept = (r_tx_state == TX_IDLE) && tx_start;
    assign w_tx_tick   = (r_tx_cnt == 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:   if (tx_start) w_tx_next = TX_START;
            TX_START:  if (w_tx_tick) w_tx_next = TX_DATA;
`ifdef UART_TXRX_PARITY_EN
            TX_DATA:   if (w_tx_tick && r_tx_bit == 3'(DATA_BITS-1)) w_tx_next = TX_PARITY;
            TX_PARITY: if (w_tx_tick) w_tx_next = TX_STOP;
`else
            TX_DATA:   if (w_tx_tick && r_tx_bit == 3'(DATA_BITS-1)) w_tx_next = TX_STOP;
`endif
            TX_STOP:   if (w_tx_tick) w_tx_next = TX_IDLE;
            default:   w_tx_next = TX_IDLE;
        endcase
    end

    // Divider is frozen per frame so baud_div changes only affect the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_cnt   <= '0;
            r_tx_div   <= '0;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx_par   <= 1'b0;
        end else if (w_tx_accept) begin
            r_tx_cnt   <= w_div_eff;
            r_tx_div   <= w_div_eff;
            r_tx_shift <= tx_data;
            r_tx_bit   <= '0;
            r_tx_par   <= ^tx_data;
        end else if (r_tx_state != TX_IDLE) begin
            if (w_tx_tick) begin
                r_tx_cnt <= r_tx_div;
                if (r_tx_state == TX_DATA) begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt - 32'd1;
            end
        end
    end

    always_comb begin
        tx      = 1'b1;
        tx_busy = (r_tx_state != TX_IDLE);
        case (r_tx_state)
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = r_tx_shift[0];
`ifdef UART_TXRX_PARITY_EN
            TX_PARITY: tx = r_tx_par;
`endif
            default:   tx = 1'b1;
        endcase
    end

    uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_div_eff   (w_div_eff),
        .i_rx        (rx),
        .o_data      (rx_data),
        .o_valid     (rx_valid),
        .o_frame_err (rx_frame_err)
    );
endmodule

// File: tb/tb_uart_txrx_core.sv
// Bench for uart_txrx_core: per-cycle Tx waveform model, Rx expectation queue with timing windows,
// plus hand-computed literal checks for the directed scenarios.
module tb_uart_txrx_core;
    localparam int SYNC    = 2;
    localparam int MIN_DIV = 4;
`ifdef UART_TXRX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, tx_start = 1'b0, lb = 1'b0, rx_drv = 1'b1;
    logic [31:0] baud_div = 32'd10;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_busy, rx_valid, rx_frame_err, tx, rx_line;
    logic [7:0]  rx_data;

    assign rx_line = lb ? tx : rx_drv;

    uart_txrx_core #(.SYNC_STAGES(SYNC), .MIN_DIV(MIN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .tx(tx), .rx(rx_line)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, cyc = 0, busy_total = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; logic [7:0] data; int lo; int hi; } rx_exp_t;
    bit        txq[$];
    rx_exp_t   rxq[$];
    logic [7:0] rx_last = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_bit(input bit v, input int d);
        repeat (d) txq.push_back(v);
    endtask

    // Model: each accepted request expands into one expected tx level per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) txq.delete();
        else begin : mdl
            bit         idle;
            int         d, s;
            logic [7:0] b;
            idle = (txq.size() == 0);
            if (!idle) void'(txq.pop_front());
            if (tx_start && idle) begin
                d = (baud_div < MIN_DIV) ? MIN_DIV : int'(baud_div);
                b = tx_data;
                push_bit(1'b0, d);
                for (int i = 0; i < 8; i++) push_bit(b[i], d);
`ifdef UART_TXRX_PARITY_EN
                push_bit(^b, d);
`endif
                push_bit(1'b1, d);
                if (lb) begin
                    s = cyc + 1 + (NBITS - 1) * d;
                    rxq.push_back('{1, b, s + d / 2, s + d / 2 + SYNC + 3});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) rx_last = 8'h00;
        else begin : cmp
            rx_exp_t e;
            chk("tx", tx, (txq.size() != 0) ? txq[0] : 1'b1);
            chk("tx_busy", tx_busy, txq.size() != 0);
            if (tx_busy) busy_total++;
            if (rx_valid || rx_frame_err) begin
                if (rxq.size() == 0) chk("rx_unexpected", {rx_frame_err, rx_valid}, 0);
                else begin
                    e = rxq.pop_front();
                    chk("rx_kind", {rx_frame_err, rx_valid}, e.kind);
                    chk("rx_in_window", (cyc >= e.lo) && (cyc <= e.hi), 1);
                    if (e.kind == 1) rx_last = e.data;
                end
            end
            chk("rx_data", rx_data, rx_last);
        end
    end

    task automatic send_rx(input logic [7:0] b, input logic stop);
        int d;
        d = int'(baud_div);
        rx_drv = 1'b0; repeat (d) @(negedge clk);
        for (int i = 0; i < 8; i++) begin rx_drv = b[i]; repeat (d) @(negedge clk); end
`ifdef UART_TXRX_PARITY_EN
        rx_drv = ^b; repeat (d) @(negedge clk);
`endif
        rxq.push_back('{stop ? 1 : 2, b, cyc + d / 2, cyc + d / 2 + SYNC + 3});
        rx_drv = stop; repeat (d) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [7:0] b);
        tx_data = b; tx_start = 1'b1; @(negedge clk); tx_start = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int t = 0;
        while (tx_busy && t < 5000) begin @(negedge clk); t++; end
        chk("tx_idle_timeout", tx_busy, 0);
    endtask

    task automatic wait_rxq();
        int t = 0;
        while (rxq.size() != 0 && t < 1000) begin @(negedge clk); t++; end
        chk("rx_pending", rxq.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: no finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        bit a5_bits[8];
        a5_bits = '{1, 0, 1, 0, 0, 1, 0, 1};
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_frame_err", rx_frame_err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA5 at div 10, sampled mid-bit
        baud_div = 32'd10; b0 = busy_total;
        pulse_start(8'hA5);
        repeat (5) @(negedge clk); chk("a5_start", tx, 0);
        for (int k = 0; k < 8; k++) begin
            repeat (10) @(negedge clk); chk($sformatf("a5_bit%0d", k), tx, a5_bits[k]);
        end
`ifdef UART_TXRX_PARITY_EN
        repeat (10) @(negedge clk); chk("a5_parity", tx, 0);
`endif
        repeat (10) @(negedge clk); chk("a5_stop", tx, 1);
        wait_tx_idle();
        chk("a5_busy_cycles", busy_total - b0, (NBITS == 11) ? 110 : 100);

        // second request 40 cycles in is ignored
        b0 = busy_total;
        pulse_start(8'h5A);
        repeat (39) @(negedge clk);
        pulse_start(8'hFF);
        wait_tx_idle();
        chk("dbl_busy_cycles", busy_total - b0, (NBITS == 11) ? 110 : 100);

        // back-to-back at div 4: request on first idle cycle is taken
        baud_div = 32'd4; b0 = busy_total;
        pulse_start(8'h0F);
        wait_tx_idle();
        pulse_start(8'hF0);
        chk("b2b_accepted", tx_busy, 1);
        wait_tx_idle();
        chk("b2b_busy_cycles", busy_total - b0, (NBITS == 11) ? 88 : 80);

        // div 2 clamps to 4
        baud_div = 32'd2; b0 = busy_total;
        pulse_start(8'h96);
        wait_tx_idle();
        chk("clamp_busy_cycles", busy_total - b0, (NBITS == 11) ? 44 : 40);

        // async reset mid-frame
        pulse_start(8'h96);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", tx_busy, 0);
        chk("rst_mid_valid", rx_valid, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // loopback 0x3C at div 16
        baud_div = 32'd16; lb = 1'b1;
        pulse_start(8'h3C);
        wait_tx_idle();
        wait_rxq();
        lb = 1'b0;
        chk("lb_byte", rx_data, 8'h3C);

        // 3-cycle glitch is rejected
        baud_div = 32'd10;
        rx_drv = 1'b0; repeat (3) @(negedge clk);
        rx_drv = 1'b1; repeat (30) @(negedge clk);
        chk("glitch_rx_data", rx_data, 8'h3C);

        // two frames with no gap after the stop bit
        send_rx(8'h81, 1'b1);
        send_rx(8'h7E, 1'b1);
        wait_rxq();
        chk("b2b_rx_byte", rx_data, 8'h7E);

        // bad stop bit, line held low, then recovery
        send_rx(8'h55, 1'b0);
        repeat (30) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        wait_rxq();
        chk("ferr_rx_data_kept", rx_data, 8'h7E);
        send_rx(8'hC3, 1'b1);
        wait_rxq();
        chk("after_ferr_byte", rx_data, 8'hC3);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_txrx_core.md
Name: uart_txrx_core

Overview:
- Bit-level UART transmitter/receiver serving as the execution stage beneath the BK UART register block.
- Consumes the register block's clocks-per-bit setting, send byte and one-cycle send strobe.
- Serialises the send byte onto Tx and deserialises Rx into bytes, each byte delivered with a one-cycle valid pulse.
- Reports busy status back to the register block for its status word.

Parameters:
- SYNC_STAGES, 2, number of flops in the Rx metastability synchroniser (minimum 2).
- MIN_DIV, 4, smallest clocks-per-bit honoured; lower programmed values are clamped to this.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- baud_div  in  32  clocks per UART bit.
- tx_data  in  8  byte to transmit.
- tx_start  in  1  one-cycle transmit request.
- tx_busy  out  1  high while a frame is being transmitted.
- rx_data  out  8  last correctly received byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_frame_err  out  1  one-cycle pulse on a bad stop bit.
- tx  out  1  serial output, idle high.
- rx  in  1  serial input, asynchronous to clk.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). All state returns to idle. Output reset values:
  - tx=1, tx_busy=0, rx_data=0x00, rx_valid=0, rx_frame_err=0.
  - Rx synchroniser flops reset to 1.
- Effective divider: div_eff = max(baud_div, MIN_DIV).
  - Tx latches div_eff when a frame is accepted; Rx latches it on start-bit detect.
  - Changing baud_div mid-frame affects only the next frame.
- Tx FSM (TX_IDLE -> TX_START -> TX_DATA -> TX_STOP -> TX_IDLE):
  - tx_start is sampled only in TX_IDLE and ignored while tx_busy=1.
  - If tx_start is high in cycle N: tx_data is captured in cycle N, and tx_busy and tx go high/low respectively from cycle N+1.
  - Each bit lasts exactly div_eff cycles; 8 data bits are sent LSB first; one stop bit (1).
  - tx_busy falls at the end of the stop bit, so a frame is 10*div_eff cycles.
  - Back-to-back: tx_start on the cycle tx_busy is low is accepted.
- Rx FSM (RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE, plus RX_WAITHI):
  - Rx runs on the synchronised signal (SYNC_STAGES latency).
  - RX_IDLE: a falling edge enters RX_START and loads a counter with div_eff>>1.
  - RX_START: at mid-bit, sample; if 1 (glitch), return to RX_IDLE with no outputs.
  - RX_DATA: sample every div_eff cycles, 8 bits, LSB first.
  - RX_STOP: sample at mid stop bit.
    - If 1: rx_data updates and rx_valid pulses for exactly one cycle, the cycle after the sample.
    - If 0: rx_frame_err pulses, rx_data is unchanged, then enter RX_WAITHI, which waits for synchronised rx=1 before RX_IDLE.
  - Rx returns to idle at mid stop bit, so a start bit immediately after the stop bit is caught.
- Tx and Rx are fully independent; loopback of tx to rx is legal.
- Counters are 32-bit, count down to 1, and reload; no wrap-around is possible because div_eff>=MIN_DIV.
- Reset asserted mid-frame aborts immediately: tx goes to 1 and no partial rx_valid is produced.

Optional Feature:
- Macro: UART_TXRX_PARITY_EN.
- Defined:
  - Tx inserts an even-parity bit between the data and stop bits, giving an 11*div_eff-cycle frame.
  - Rx checks parity in an RX_PARITY state. On a mismatch, rx_frame_err pulses at the stop-bit sample instead of rx_valid, and rx_data is unchanged.
- Undefined: 8N1 framing only; the parity state and logic are absent.

Decomposition:
- Package uart_txrx_pkg holds:
  - the tx/rx state enumerations;
  - constant DATA_BITS=8;
  - the default MIN_DIV;
  - the div_eff clamp function.
- One sub-module is natural: uart_rx_sampler, containing the synchroniser, start detect, mid-bit counter, Rx FSM and error logic.
- The Tx FSM stays in the top module.

Test Plan:
- baud_div=10, tx_data=0xA5, tx_start pulse: tx = 0 for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then 1. tx_busy is high for exactly 100 cycles.
- Loopback tx->rx, baud_div=16, send 0x3C: exactly one rx_valid pulse with rx_data=0x3C, and no rx_frame_err.
- baud_div=10, rx driven low for 3 cycles then high: no rx_valid, no rx_frame_err, and Rx back to idle.
- Drive a frame 0x55 with stop bit=0, then hold the line low 30 cycles: one rx_frame_err pulse, rx_data keeps its previous value, and no new frame is detected until rx returns high.
- tx_start pulsed at cycles 0 and 40 with baud_div=10: the second pulse is ignored, and only one 100-cycle frame is produced.
- baud_div=2: frame timing uses 4 cycles per bit (40-cycle frame). Reset asserted mid-frame: tx=1 and tx_busy=0 immediately, asynchronously.
